// File: rtl/full_connect_layer1.sv
// First fully-connected DNN layer: sequences 128 neurons x 8 chunks through an
// external MultAdder, accumulates, applies ReLU/requantisation, packs int8 results.
//
// state | meaning
// IDLE  | waiting for ena; addresses parked at base
// RUN   | one chunk per enabled cycle; ena=0 pauses
// DONE  | results and overflow held until ena drops
module full_connect_layer1 #(
  parameter int          SHIFT    = 7,
  parameter logic [31:0] ROM_BASE = 32'd0
) (
  input  logic          clk,
  input  logic          iRst,
  input  logic          ena,
  input  logic [1023:0] data_from_rom,
  input  logic [1023:0] data_from_ram,
  input  logic [14:0]   data_from_MultAdder,
  input  logic          overflow_from_MultAdder,
  output logic          overflow,
  output logic          done,
  output logic [31:0]   addr_to_rom,
  output logic [2:0]    addr_to_ram,
  output logic [1023:0] opr1_to_MultAdder,
  output logic [1023:0] opr2_to_MultAdder,
  output logic [1023:0] data_to_ram
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [9:0]         idx;
  logic signed [17:0] acc;
  logic signed [17:0] mult_ext;
  logic signed [17:0] sum;
  logic signed [17:0] shifted;
  logic [7:0]         q;

  assign opr1_to_MultAdder = data_from_rom;
  assign opr2_to_MultAdder = data_from_ram;

  assign addr_to_rom = (state == RUN) ? ROM_BASE + {22'd0, idx} : ROM_BASE;
  assign addr_to_ram = (state == RUN) ? idx[2:0] : 3'd0;

  assign mult_ext = {{3{data_from_MultAdder[14]}}, data_from_MultAdder};
  assign sum      = acc + mult_ext;
  assign shifted  = sum >>> SHIFT;

  // ReLU then clip to the positive int8 range
  always_comb begin
    q = 8'd0;
    if (sum <= 18'sd0)
      q = 8'd0;
    else if (shifted > 18'sd127)
      q = 8'd127;
    else
      q = shifted[7:0];
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      idx         <= 10'd0;
      acc         <= 18'sd0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      data_to_ram <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ena) begin
            overflow <= 1'b0;
            acc      <= 18'sd0;
            idx      <= 10'd0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (ena) begin
            overflow <= overflow | overflow_from_MultAdder;
            if (idx[2:0] != 3'd7) begin
              acc <= sum;
            end else begin
              data_to_ram[{idx[9:3], 3'b000} +: 8] <= q;
              acc <= 18'sd0;
            end
            if (idx == 10'd1023) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx <= idx + 10'd1;
            end
          end
        end
        DONE: begin
          if (!ena) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_connect_layer1.sv
// Directed bench for full_connect_layer1: emulates the MultAdder and checks
// latency, addressing, requantisation, overflow, pause and reset behaviour.
module tb_full_connect_layer1;

  logic          clk;
  logic          iRst;
  logic          ena;
  logic [1023:0] data_from_rom;
  logic [1023:0] data_from_ram;
  logic [14:0]   mult;
  logic          ovf_in;
  logic          overflow;
  logic          done;
  logic [31:0]   addr_to_rom;
  logic [2:0]    addr_to_ram;
  logic [1023:0] opr1;
  logic [1023:0] opr2;
  logic [1023:0] data_to_ram;

  logic          use_fn;
  logic [14:0]   const_val;
  int            checks;
  int            failures;

  full_connect_layer1 dut (
    .clk                     (clk),
    .iRst                    (iRst),
    .ena                     (ena),
    .data_from_rom           (data_from_rom),
    .data_from_ram           (data_from_ram),
    .data_from_MultAdder     (mult),
    .overflow_from_MultAdder (ovf_in),
    .overflow                (overflow),
    .done                    (done),
    .addr_to_rom             (addr_to_rom),
    .addr_to_ram             (addr_to_ram),
    .opr1_to_MultAdder       (opr1),
    .opr2_to_MultAdder       (opr2),
    .data_to_ram             (data_to_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern mode: term for neuron n, chunk c is 16n+c, so each neuron sums to
  // 128n+28 and requantises to exactly n.
  always_comb begin
    mult = const_val;
    if (use_fn) mult = {4'b0, addr_to_rom[9:3], 1'b0, addr_to_rom[2:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs from IDLE to DONE, checking addresses and operand mirroring each cycle.
  task automatic do_run(input int pause_at, input int pause_len, input int ovf_at,
                        output int cycles, output logic ovf_start);
    int k;
    int err;
    logic [31:0] r;
    logic [31:0] held;
    err = 0;
    k = 0;
    cycles = 0;
    ena = 1'b1;
    tick();
    ovf_start = overflow;
    while (!done && cycles < 1200) begin
      r = $urandom;
      data_from_rom = {32{r}};
      data_from_ram = {32{~r}};
      ovf_in = (k == ovf_at);
      #1;
      if (opr1 !== data_from_rom || opr2 !== data_from_ram) err++;
      if (addr_to_rom !== 32'(k) || addr_to_ram !== k[2:0]) err++;
      if (k == pause_at) begin
        held = addr_to_rom;
        ena = 1'b0;
        ovf_in = 1'b1;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          cycles++;
          if (addr_to_rom !== held || addr_to_ram !== held[2:0] || done !== 1'b0) err++;
        end
        ena = 1'b1;
        ovf_in = 1'b0;
      end
      tick();
      cycles++;
      k++;
    end
    ovf_in = 1'b0;
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL run_addr_mirror errors=%0d required=0", err);
    end
  endtask

  task automatic go_idle();
    ena = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    ena = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || overflow !== 1'b0 || data_to_ram !== '0 ||
        addr_to_rom !== 32'd0 || addr_to_ram !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs done=%b ovf=%b rom=%0d ram=%0d required all zero",
               done, overflow, addr_to_rom, addr_to_ram);
    end
    iRst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    logic os;
    use_fn = 1'b0;
    const_val = 15'd323;
    do_run(-1, 0, -1, cyc, os);
    checks++;
    if (cyc !== 1024) begin
      failures++;
      $display("FAIL basic_latency got=%0d required=1024", cyc);
    end
    checks++;
    if (data_to_ram !== {128{8'h14}}) begin
      failures++;
      $display("FAIL basic_data got=%h required all 14", data_to_ram[63:0]);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_overflow got=%b required=0", overflow);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done !== 1'b1 || addr_to_rom !== 32'd0 || data_to_ram !== {128{8'h14}}) begin
      failures++;
      $display("FAIL done_hold done=%b rom=%0d required done=1 rom=0", done, addr_to_rom);
    end
    go_idle();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_clear got=%b required=0", done);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic os;
    const_val = 15'd323;
    do_run(-1, 0, 517, cyc, os);
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL ovf_at_done ovf=%b done=%b required 1 1", overflow, done);
    end
    go_idle();
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_held_idle got=%b required=1", overflow);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    logic os;
    const_val = 15'h3FFF;
    do_run(-1, 0, -1, cyc, os);
    checks++;
    if (os !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared_on_start got=%b required=0", os);
    end
    checks++;
    if (data_to_ram !== {128{8'h7F}}) begin
      failures++;
      $display("FAIL saturation got=%h required all 7f", data_to_ram[63:0]);
    end
    go_idle();
  endtask

  task automatic test_relu();
    int cyc;
    logic os;
    const_val = 15'h7FFB;
    do_run(-1, 0, -1, cyc, os);
    checks++;
    if (data_to_ram !== '0) begin
      failures++;
      $display("FAIL relu got=%h required all 00", data_to_ram[63:0]);
    end
    go_idle();
  endtask

  task automatic test_boundary();
    int cyc;
    logic os;
    const_val = 15'd2031;
    do_run(-1, 0, -1, cyc, os);
    checks++;
    if (data_to_ram !== {128{8'h7E}}) begin
      failures++;
      $display("FAIL below_clip got=%h required all 7e", data_to_ram[63:0]);
    end
    go_idle();
  endtask

  task automatic test_pattern_pause();
    int cyc;
    logic os;
    logic [1023:0] expv;
    for (int n = 0; n < 128; n++) expv[8*n +: 8] = 8'(n);
    use_fn = 1'b1;
    do_run(300, 10, -1, cyc, os);
    checks++;
    if (cyc !== 1034) begin
      failures++;
      $display("FAIL pause_latency got=%0d required=1034", cyc);
    end
    checks++;
    if (data_to_ram !== expv) begin
      failures++;
      $display("FAIL pattern_data got=%h required=%h", data_to_ram[127:0], expv[127:0]);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL pause_ovf_frozen got=%b required=0", overflow);
    end
    go_idle();
    use_fn = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int cyc;
    logic os;
    const_val = 15'd1000;
    ena = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      ovf_in = (i == 20);
      tick();
    end
    ovf_in = 1'b0;
    checks++;
    if (addr_to_rom !== 32'd100 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset rom=%0d ovf=%b required 100 1", addr_to_rom, overflow);
    end
    @(negedge clk);
    iRst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || overflow !== 1'b0 || data_to_ram !== '0 ||
        addr_to_rom !== 32'd0 || addr_to_ram !== 3'd0) begin
      failures++;
      $display("FAIL midrun_reset done=%b ovf=%b rom=%0d ram=%0d required all zero",
               done, overflow, addr_to_rom, addr_to_ram);
    end
    tick();
    iRst = 1'b0;
    do_run(-1, 0, -1, cyc, os);
    checks++;
    if (cyc !== 1024 || data_to_ram !== {128{8'h3E}}) begin
      failures++;
      $display("FAIL rerun cycles=%0d data=%h required 1024 all 3e", cyc, data_to_ram[63:0]);
    end
    go_idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    iRst = 1'b1;
    ena = 1'b0;
    ovf_in = 1'b0;
    use_fn = 1'b0;
    const_val = 15'd0;
    data_from_rom = {128{8'h01}};
    data_from_ram = {128{8'h02}};
    test_reset();
    test_basic();
    test_done_hold();
    test_overflow();
    test_saturation();
    test_relu();
    test_boundary();
    test_pattern_pause();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
